stage5_seq_ctrl: RTL and testbench

- Sequences the interval-histogram datapath (the per-lane interval classifier, count update, and alpha/beta arithmetic stage) over one J-sample job.
- Owns the architectural state that the datapath only computes combinationally: per-lane interval counts, running max count and winning mode.
- Clears the state at job start, accepts one sample beat per handshake, and commits the datapath's next-state on every accepted beat.
- Reports the final per-lane mode and max count with a done pulse. Sits between the sample producer and the stage-5 datapath instance.

---
 rtl/stage5_pkg.sv | 19 +
 rtl/stage5_lane_state.sv | 59 +++++
 rtl/stage5_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_stage5_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage5_pkg.sv
// Shared types and default sizing for the stage-5 interval-histogram sequencer.
package stage5_pkg;

    localparam int unsigned DEF_PARALLEL  = 2;
    localparam int unsigned DEF_INTERVALS = 8;
    localparam int unsigned DEF_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    typedef logic [DEF_CNT_W-1:0]     cnt_t;
    typedef cnt_t [DEF_INTERVALS-1:0] lane_cnt_t;
    typedef logic [DEF_INTERVALS-1:0] onehot_t;

endpackage

// File: rtl/stage5_lane_state.sv
// One lane's architectural histogram state: interval counts, running max and winning mode.
module stage5_lane_state
    import stage5_pkg::*;
#(
    parameter int unsigned INTERVALS = DEF_INTERVALS,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       commit_i,
    input  logic                       uadd_i,
    input  logic [INTERVALS*CNT_W-1:0] cnt_nxt_i,
    input  logic [CNT_W-1:0]           max_nxt_i,
    input  logic [INTERVALS-1:0]       mode_nxt_i,
    output logic [INTERVALS*CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0]           max_o,
    output logic [INTERVALS-1:0]       mode_o
);

    logic [INTERVALS*CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]           max_q, max_d;
    logic [INTERVALS-1:0]       mode_q, mode_d;

    // Max and mode only move on uadd so the datapath's zeroed candidates never land.
    always_comb begin
        cnt_d  = cnt_q;
        max_d  = max_q;
        mode_d = mode_q;
        if (clear_i) begin
            cnt_d  = '0;
            max_d  = '0;
            mode_d = '0;
        end else if (commit_i) begin
            cnt_d = cnt_nxt_i;
            if (uadd_i) begin
                max_d  = max_nxt_i;
                mode_d = mode_nxt_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            max_q  <= '0;
            mode_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            max_q  <= max_d;
            mode_q <= mode_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign max_o  = max_q;
    assign mode_o = mode_q;

endmodule

// File: rtl/stage5_seq_ctrl.sv
// Job sequencer for the stage-5 histogram datapath: clears, commits beats, signals completion.
module stage5_seq_ctrl
    import stage5_pkg::*;
#(
    parameter int unsigned PARALLEL  = DEF_PARALLEL,
    parameter int unsigned INTERVALS = DEF_INTERVALS,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                                CLK_i,
    input  logic                                RST_ni,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic [CNT_W-1:0]                    j_size_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    output logic [PARALLEL*INTERVALS*CNT_W-1:0] cnt_o,
    input  logic [PARALLEL*INTERVALS*CNT_W-1:0] cnt_nxt_i,
    output logic [PARALLEL*CNT_W-1:0]           max_o,
    input  logic [PARALLEL*CNT_W-1:0]           max_nxt_i,
    input  logic [PARALLEL-1:0]                 uadd_i,
    input  logic [PARALLEL*INTERVALS-1:0]       mode_nxt_i,
    output logic [PARALLEL*INTERVALS-1:0]       best_mode_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [CNT_W-1:0]                    step_o
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] jsize_q, jsize_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] step_inc;
    logic             lane_clear;
    logic             lane_commit;
    logic             in_ready;
    logic             busy;
    logic             done;

    assign step_inc = step_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        jsize_d     = jsize_q;
        step_d      = step_q;
        lane_clear  = 1'b0;
        lane_commit = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    jsize_d = j_size_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    lane_clear = 1'b1;
                    step_d     = '0;
                    state_d    = (jsize_q != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                // Abort wins over a beat presented in the same cycle.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (in_valid_i) begin
                    lane_commit = 1'b1;
                    step_d      = step_inc;
                    if (step_inc == jsize_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done    = !abort_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            state_q <= IDLE;
            jsize_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            jsize_q <= jsize_d;
            step_q  <= step_d;
        end
    end

    for (genvar l = 0; l < PARALLEL; l++) begin : g_lane
        stage5_lane_state #(
            .INTERVALS (INTERVALS),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk_i      (CLK_i),
            .rst_ni     (RST_ni),
            .clear_i    (lane_clear),
            .commit_i   (lane_commit),
            .uadd_i     (uadd_i[l]),
            .cnt_nxt_i  (cnt_nxt_i[l*INTERVALS*CNT_W +: INTERVALS*CNT_W]),
            .max_nxt_i  (max_nxt_i[l*CNT_W +: CNT_W]),
            .mode_nxt_i (mode_nxt_i[l*INTERVALS +: INTERVALS]),
            .cnt_o      (cnt_o[l*INTERVALS*CNT_W +: INTERVALS*CNT_W]),
            .max_o      (max_o[l*CNT_W +: CNT_W]),
            .mode_o     (best_mode_o[l*INTERVALS +: INTERVALS])
        );
    end

    assign in_ready_o = in_ready;
    assign busy_o     = busy;
    assign done_o     = done;
    assign step_o     = step_q;

endmodule

// File: tb/tb_stage5_seq_ctrl.sv
// Directed self-checking bench for stage5_seq_ctrl with a small behavioural datapath in the loop.
module tb_stage5_seq_ctrl;

    localparam int P  = 2;
    localparam int NI = 8;
    localparam int CW = 16;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [CW-1:0]       j_size;
    logic                in_valid;
    logic                in_ready;
    logic [P*NI*CW-1:0]  cnt_o;
    logic [P*NI*CW-1:0]  cnt_nxt;
    logic [P*CW-1:0]     max_o;
    logic [P*CW-1:0]     max_nxt;
    logic [P-1:0]        uadd;
    logic [P*NI-1:0]     mode_nxt;
    logic [P*NI-1:0]     best_mode;
    logic                busy;
    logic                done;
    logic [CW-1:0]       step;

    int cls [P];
    int checks;
    int errors;

    stage5_seq_ctrl #(
        .PARALLEL  (P),
        .INTERVALS (NI),
        .CNT_W     (CW)
    ) dut (
        .CLK_i       (clk),
        .RST_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .j_size_i    (j_size),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .cnt_o       (cnt_o),
        .cnt_nxt_i   (cnt_nxt),
        .max_o       (max_o),
        .max_nxt_i   (max_nxt),
        .uadd_i      (uadd),
        .mode_nxt_i  (mode_nxt),
        .best_mode_o (best_mode),
        .busy_o      (busy),
        .done_o      (done),
        .step_o      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: bump the classified interval, strict greater-than for a new max.
    logic [CW-1:0] dp_c;
    always_comb begin
        cnt_nxt  = cnt_o;
        max_nxt  = '0;
        mode_nxt = '0;
        uadd     = '0;
        dp_c     = '0;
        for (int l = 0; l < P; l++) begin
            if (cls[l] >= 0) begin
                dp_c = cnt_o[(l*NI+cls[l])*CW +: CW] + 1'b1;
                cnt_nxt[(l*NI+cls[l])*CW +: CW] = dp_c;
                if (dp_c > max_o[l*CW +: CW]) begin
                    uadd[l]                = 1'b1;
                    max_nxt[l*CW +: CW]    = dp_c;
                    mode_nxt[l*NI +: NI]   = NI'(1) << cls[l];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        j_size   = '0;
        in_valid = 1'b0;
        cls[0]   = -1;
        cls[1]   = -1;

        #12;
        chk("rst_cnt",   256'(cnt_o), 256'd0);
        chk("rst_max",   256'(max_o), 256'd0);
        chk("rst_mode",  256'(best_mode), 256'd0);
        chk("rst_step",  256'(step), 256'd0);
        chk("rst_flags", 256'({in_ready, busy, done}), 256'd0);
        rst_n = 1'b1;
        tick();

        // Job A: j_size=4, lane0 intervals 0,2,2,1
        j_size = 16'd4;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("a_clear_busy", 256'({busy, in_ready}), 256'b10);
        tick();
        chk("a_run_ready", 256'(in_ready), 256'd1);
        in_valid = 1'b1;
        cls[0] = 0; tick();
        cls[0] = 2; tick();
        cls[0] = 2; tick();
        chk("a_step3", 256'(step), 256'd3);
        chk("a_done_early", 256'(done), 256'd0);
        cls[0] = 1; tick();
        in_valid = 1'b0;
        cls[0]   = -1;
        chk("a_done", 256'({done, in_ready}), 256'b10);
        chk("a_step", 256'(step), 256'd4);
        chk("a_cnt0", 256'(cnt_o[47:0]), 256'h0002_0001_0001);
        chk("a_cnt_rest", 256'(cnt_o[255:48]), 256'd0);
        chk("a_max0", 256'(max_o[15:0]), 256'd2);
        chk("a_mode0", 256'(best_mode[7:0]), 256'h04);
        tick();
        chk("a_done_pulse", 256'({done, busy}), 256'd0);
        chk("a_hold_mode", 256'(best_mode[7:0]), 256'h04);

        // Job B: j_size=0 goes straight through CLEAR to DONE
        j_size = 16'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("b_clear", 256'({busy, in_ready, done}), 256'b100);
        tick();
        chk("b_done", 256'({done, in_ready}), 256'b10);
        chk("b_cnt", 256'(cnt_o), 256'd0);
        chk("b_max_mode_step", 256'({max_o, best_mode, step}), 256'd0);
        tick();
        chk("b_idle", 256'({done, busy, in_ready}), 256'd0);

        // Job C: j_size=3 with gapped valid 1,0,0,1,0,1 on lane1 interval 4
        j_size = 16'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cls[1] = 4;
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b0; tick();
        chk("c_step_gap", 256'(step), 256'd1);
        chk("c_no_timeout", 256'({busy, done}), 256'b10);
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; tick();
        in_valid = 1'b0;
        cls[1]   = -1;
        chk("c_done", 256'(done), 256'd1);
        chk("c_step", 256'(step), 256'd3);
        chk("c_cnt1_i4", 256'(cnt_o[207:192]), 256'd3);
        chk("c_max1_mode1", 256'({max_o[31:16], best_mode[15:8]}), 256'h0003_10);
        tick();

        // Job D: tie on lane1, interval 5 then 3 -> first keeps the mode
        j_size = 16'd2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        cls[1] = 5; tick();
        cls[1] = 3; tick();
        in_valid = 1'b0;
        cls[1]   = -1;
        chk("d_done", 256'(done), 256'd1);
        chk("d_mode1", 256'(best_mode[15:8]), 256'h20);
        chk("d_max1", 256'(max_o[31:16]), 256'd1);
        tick();

        // Job E: abort with a valid beat at step 2 of j_size=5
        j_size = 16'd5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        cls[0] = 0; tick();
        tick();
        chk("e_step2", 256'(step), 256'd2);
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        cls[0]   = -1;
        chk("e_idle", 256'({busy, done, in_ready}), 256'd0);
        chk("e_step_hold", 256'(step), 256'd2);
        chk("e_not_commit", 256'(cnt_o[15:0]), 256'd2);
        tick();
        chk("e_no_done", 256'(done), 256'd0);
        j_size = 16'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("e_cleared", 256'({cnt_o, max_o, best_mode, step}), 256'd0);
        in_valid = 1'b1;
        cls[0] = 7; tick();
        in_valid = 1'b0;
        cls[0]   = -1;
        chk("e_j1_done", 256'({done, step}), 256'h1_0001);
        chk("e_j1_mode", 256'(best_mode[7:0]), 256'h80);
        tick();

        // Job F: start during RUN is ignored; j_size=3 still needs 3 beats
        j_size = 16'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        cls[0] = 1; tick();
        start  = 1'b1;
        j_size = 16'd1;
        tick();
        start = 1'b0;
        chk("f_ignore_start", 256'({done, busy, step}), 256'h1_0002);
        tick();
        in_valid = 1'b0;
        cls[0]   = -1;
        chk("f_done", 256'({done, step}), 256'h1_0003);
        tick();

        // Job G: async reset mid-RUN
        j_size = 16'd4;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        cls[1] = 6; tick();
        tick();
        in_valid = 1'b0;
        cls[1]   = -1;
        chk("g_pre_reset", 256'(step), 256'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("g_rst_cnt", 256'(cnt_o), 256'd0);
        chk("g_rst_regs", 256'({max_o, best_mode, step}), 256'd0);
        chk("g_rst_flags", 256'({in_ready, busy, done}), 256'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("g_idle_after", 256'({busy, in_ready, done}), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
